// File: rtl/move_select_scan.sv
// move_select_scan: raster-scans per-direction weight tables and picks the next move by turn-dependent category priority
module move_select_scan #(
  parameter int BRD_W = 19,
  parameter int BRD_H = 19,
  parameter int NDIR = 4,
  parameter int NCAT = 9,
  parameter int FW = 3,
  parameter int RD_LAT = 1,
  parameter logic [NCAT*4-1:0] PRIO0 = 36'h438765210,
  parameter logic [NCAT*4-1:0] PRIO1 = 36'h483765210,
  parameter int DEF_X = 9,
  parameter int DEF_Y = 9,
  localparam int SW = FW + $clog2(NDIR)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      turn,
  output logic                      rd_req,
  output logic [4:0]                rd_x,
  output logic [4:0]                rd_y,
  input  logic [NDIR*NCAT*FW-1:0]   rd_data,
  output logic                      busy,
  output logic                      done,
  output logic                      move_found,
  output logic [4:0]                move_x,
  output logic [4:0]                move_y,
  output logic [3:0]                move_cat,
  output logic [SW-1:0]             move_weight
);
  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_PICK, S_DONE} state_t;
  state_t state, state_nx;
  logic [4:0] cx, cy;
  logic turn_q, last, accept;
  logic [RD_LAT-1:0] tag_v;
  logic [4:0] tag_x [RD_LAT];
  logic [4:0] tag_y [RD_LAT];
  logic [SW-1:0] max_w [NCAT];
  logic [4:0] loc_x [NCAT];
  logic [4:0] loc_y [NCAT];
  logic [SW-1:0] sums [NCAT];
  logic pick_found;
  logic [3:0] pick_cat, p_cat;
  logic [SW-1:0] pick_w;
  logic [4:0] pick_x, pick_y;
  assign last = cx == 5'(BRD_W - 1) && cy == 5'(BRD_H - 1);
  assign accept = state == S_IDLE && start && !abort;
  assign rd_req = state == S_SCAN;
  assign rd_x = cx;
  assign rd_y = cy;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  always_comb begin
    state_nx = abort ? S_IDLE :
               state == S_IDLE  ? (start ? S_SCAN : S_IDLE) :
               state == S_SCAN  ? (last ? S_DRAIN : S_SCAN) :
               state == S_DRAIN ? (tag_v == '0 ? S_PICK : S_DRAIN) :
               state == S_PICK  ? S_DONE : S_IDLE;
  end
  always_comb begin
    for (int k = 0; k < NCAT; k++) begin
      sums[k] = '0;
      for (int d = 0; d < NDIR; d++)
        sums[k] = sums[k] + SW'(rd_data[(d*NCAT+k)*FW +: FW]);
    end
  end
  always_comb begin
    pick_found = 1'b0;
    pick_cat = '0;
    pick_w = '0;
    pick_x = 5'(DEF_X);
    pick_y = 5'(DEF_Y);
    p_cat = '0;
    for (int j = 0; j < NCAT; j++) begin
      p_cat = turn_q ? PRIO1[j*4 +: 4] : PRIO0[j*4 +: 4];
      if (int'(p_cat) < NCAT && max_w[p_cat] != '0) begin
        pick_found = 1'b1;
        pick_cat = p_cat;
        pick_w = max_w[p_cat];
        pick_x = loc_x[p_cat];
        pick_y = loc_y[p_cat];
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cx <= '0;
      cy <= '0;
      turn_q <= 1'b0;
      tag_v <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_x[i] <= '0;
        tag_y[i] <= '0;
      end
      for (int k = 0; k < NCAT; k++) begin
        max_w[k] <= '0;
        loc_x[k] <= '0;
        loc_y[k] <= '0;
      end
      move_found <= 1'b0;
      move_x <= 5'(DEF_X);
      move_y <= 5'(DEF_Y);
      move_cat <= '0;
      move_weight <= '0;
    end else begin
      state <= state_nx;
      tag_v[0] <= rd_req && !abort;
      tag_x[0] <= cx;
      tag_y[0] <= cy;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1] && !abort;
        tag_x[i] <= tag_x[i-1];
        tag_y[i] <= tag_y[i-1];
      end
      if (accept) begin
        turn_q <= turn;
        cx <= '0;
        cy <= '0;
      end else if (state == S_SCAN) begin
        cx <= cx == 5'(BRD_W - 1) ? '0 : cx + 5'd1;
        cy <= cx == 5'(BRD_W - 1) ? (cy == 5'(BRD_H - 1) ? '0 : cy + 5'd1) : cy;
      end
      for (int k = 0; k < NCAT; k++) begin
        if (accept) begin
          max_w[k] <= '0;
          loc_x[k] <= '0;
          loc_y[k] <= '0;
        end else if (tag_v[RD_LAT-1] && sums[k] > max_w[k]) begin
          max_w[k] <= sums[k];
          loc_x[k] <= tag_x[RD_LAT-1];
          loc_y[k] <= tag_y[RD_LAT-1];
        end
      end
      if (state == S_PICK && !abort) begin
        move_found <= pick_found;
        move_x <= pick_x;
        move_y <= pick_y;
        move_cat <= pick_cat;
        move_weight <= pick_w;
      end
    end
  end
endmodule

// File: tb/tb_move_select_scan.sv
// tb_move_select_scan: randomized scoreboard bench for move_select_scan against a board-level reference model
module tb_move_select_scan;
  localparam int W = 19, H = 19, ND = 4, NC = 9, FW = 3, LAT = 3, SW = 5, N = W * H;
  logic clk = 0, reset_n = 0, start = 0, abort = 0, turn = 0;
  logic rd_req, busy, done, move_found;
  logic [4:0] rd_x, rd_y, move_x, move_y;
  logic [3:0] move_cat;
  logic [SW-1:0] move_weight;
  logic [ND*NC*FW-1:0] rd_data = '0;
  logic [9:0] p1 = '0, p2 = '0;
  typedef struct {int found; int x; int y; int cat; int w; int cyc;} exp_t;
  exp_t q[$];
  exp_t last_exp = '{0, 9, 9, 0, 0, 0};
  exp_t e_mon, e_st;
  int bw [H][W][ND][NC];
  int prio [2][NC] = '{'{4, 3, 8, 7, 6, 5, 2, 1, 0}, '{4, 8, 3, 7, 6, 5, 2, 1, 0}};
  int cyc = 0, n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  move_select_scan #(.BRD_W(W), .BRD_H(H), .NDIR(ND), .NCAT(NC), .FW(FW), .RD_LAT(LAT),
    .PRIO0(36'h438765210), .PRIO1(36'h483765210), .DEF_X(9), .DEF_Y(9)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .turn(turn),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .busy(busy), .done(done), .move_found(move_found), .move_x(move_x), .move_y(move_y),
    .move_cat(move_cat), .move_weight(move_weight));

  function automatic logic [ND*NC*FW-1:0] pack(logic [9:0] a);
    logic [ND*NC*FW-1:0] r = '0;
    int x = int'(a[4:0]), y = int'(a[9:5]);
    if (x < W && y < H)
      for (int d = 0; d < ND; d++)
        for (int k = 0; k < NC; k++)
          r[(d*NC+k)*FW +: FW] = FW'(bw[y][x][d][k]);
    return r;
  endfunction

  // read port model: data for a request appears LAT cycles later
  always @(posedge clk) begin
    cyc <= cyc + 1;
    p1 <= {rd_y, rd_x};
    p2 <= p1;
    rd_data <= pack(p2);
  end

  function automatic int cell_sum(int x, int y, int k);
    int s = 0;
    for (int d = 0; d < ND; d++) s += bw[y][x][d][k];
    return s;
  endfunction

  function automatic exp_t model(int t);
    exp_t e = '{0, 9, 9, 0, 0, 0};
    for (int j = 0; j < NC; j++) begin
      int k = prio[t][j];
      int mx = 0;
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          if (cell_sum(x, y, k) > mx) mx = cell_sum(x, y, k);
      if (mx > 0) begin
        e.found = 1; e.cat = k; e.w = mx;
        for (int y = H - 1; y >= 0; y--)
          for (int x = W - 1; x >= 0; x--)
            if (cell_sum(x, y, k) == mx) begin e.x = x; e.y = y; end
        return e;
      end
    end
    return e;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && done) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        e_mon = q.pop_front();
        chk("done_latency", cyc, e_mon.cyc);
        chk("move_found", int'(move_found), e_mon.found);
        chk("move_x", int'(move_x), e_mon.x);
        chk("move_y", int'(move_y), e_mon.y);
        chk("move_cat", int'(move_cat), e_mon.cat);
        chk("move_weight", int'(move_weight), e_mon.w);
        chk("busy_at_done", int'(busy), 1);
        last_exp = e_mon;
      end
    end
  end

  task automatic clear_board();
    foreach (bw[y, x, d, k]) bw[y][x][d][k] = 0;
  endtask

  task automatic random_board();
    logic [NC-1:0] act = NC'($urandom);
    foreach (bw[y, x, d, k])
      bw[y][x][d][k] = (act[k] && $urandom_range(0, 15) == 0) ? int'($urandom_range(1, 3)) : 0;
  endtask

  task automatic start_scan(input int t, input bit expect_done);
    @(negedge clk);
    start = 1;
    turn = t[0];
    if (expect_done) begin
      e_st = model(t);
      e_st.cyc = cyc + 1 + N + LAT + 2;
      q.push_back(e_st);
    end
    @(negedge clk);
    start = 0;
    turn = 1'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < N + LAT + 40 && q.size() != 0; i++) @(negedge clk);
    chk("done_within_budget", q.size(), 0);
    q.delete();
    @(negedge clk);
  endtask

  task automatic chk_move(string nm, exp_t e);
    chk({nm, "_found"}, int'(move_found), e.found);
    chk({nm, "_x"}, int'(move_x), e.x);
    chk({nm, "_y"}, int'(move_y), e.y);
    chk({nm, "_cat"}, int'(move_cat), e.cat);
    chk({nm, "_weight"}, int'(move_weight), e.w);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    clear_board();
    repeat (3) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_req", int'(rd_req), 0);
    chk_move("rst", '{0, 9, 9, 0, 0, 0});
    start_scan(0, 1);
    wait_done();
    for (int d = 0; d < ND; d++) bw[7][3][d][4] = 2;
    start_scan(0, 1);
    wait_done();
    clear_board();
    bw[2][2][0][4] = 5;
    bw[10][10][1][4] = 5;
    start_scan(1, 1);
    wait_done();
    clear_board();
    start_scan(0, 1);
    wait_done();
    bw[1][1][0][8] = 3;
    bw[5][5][0][3] = 6;
    start_scan(0, 1);
    wait_done();
    start_scan(1, 1);
    wait_done();
    for (int r = 0; r < 8; r++) begin
      random_board();
      start_scan(int'($urandom_range(0, 1)), 1);
      wait_done();
    end
    random_board();
    start_scan(0, 1);
    repeat (20) @(negedge clk);
    start = 1; turn = 1;
    @(negedge clk);
    start = 0;
    repeat (20) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done();
    start_scan(1, 0);
    repeat (48) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_rd_req", int'(rd_req), 0);
    chk("abort_busy", int'(busy), 0);
    repeat (LAT + 8) @(negedge clk);
    chk_move("abort_hold", last_exp);
    start_scan(1, 1);
    wait_done();
    @(negedge clk);
    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    chk("start_abort_busy", int'(busy), 0);
    chk("start_abort_rd_req", int'(rd_req), 0);
    repeat (5) @(negedge clk);
    start_scan(0, 0);
    repeat (100) @(negedge clk);
    reset_n = 0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_rd_req", int'(rd_req), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_rd_x", int'(rd_x), 0);
    chk("midrst_rd_y", int'(rd_y), 0);
    chk_move("midrst", '{0, 9, 9, 0, 0, 0});
    @(negedge clk);
    reset_n = 1;
    last_exp = '{0, 9, 9, 0, 0, 0};
    repeat (LAT + 4) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    random_board();
    start_scan(1, 1);
    wait_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
